// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-port register file with dual write ports, bypass and bulk clear
module reg_file_mp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1,
    parameter int RD_REG     = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clr,
    input  logic                           wr_en0,
    input  logic [ADDR_WIDTH-1:0]          wr_addr0,
    input  logic [DATA_WIDTH-1:0]          wr_data0,
    input  logic                           wr_en1,
    input  logic [ADDR_WIDTH-1:0]          wr_addr1,
    input  logic [DATA_WIDTH-1:0]          wr_data1,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic                           wr_collision
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic blk0;
    logic blk1;
    logic same_addr;
    logic we0;
    logic we1;
    logic collide;

    // Writes aimed at the hardwired zero register are dropped before they reach the array.
    assign blk0      = (ZERO_REG != 0) && (wr_addr0 == '0);
    assign blk1      = (ZERO_REG != 0) && (wr_addr1 == '0);
    assign same_addr = (wr_addr0 == wr_addr1);
    assign we1       = wr_en1 && !blk1;
    assign we0       = wr_en0 && !blk0 && !(wr_en1 && same_addr);
    assign collide   = wr_en0 && wr_en1 && same_addr && !blk0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= collide;
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else begin
                if (we0) begin
                    mem[wr_addr0] <= wr_data0;
                end
                if (we1) begin
                    mem[wr_addr1] <= wr_data1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] cur;
        logic [DATA_WIDTH-1:0] nxt;

        assign addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        // cur is the stored value; nxt is what the register will hold after this edge.
        always_comb begin
            cur = mem[addr];
            nxt = cur;
            if (clr) begin
                nxt = '0;
            end else if (we1 && (wr_addr1 == addr)) begin
                nxt = wr_data1;
            end else if (we0 && (wr_addr0 == addr)) begin
                nxt = wr_data0;
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                cur = '0;
                nxt = '0;
            end
        end

        if (RD_REG == 0) begin : g_comb
            // While reset is held no write will commit, so bypass must not leak the write data.
            assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = ((BYPASS != 0) && reset) ? nxt : cur;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else begin
                    q <= (BYPASS != 0) ? nxt : cur;
                end
            end
            assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = q;
        end
    end

endmodule
